// File: rtl/test_mode_ctrl.sv
// Test-program mode controller: debounced bit-reversed switch decode,
// per-mode CPU reset hold, and free-run / single-step CPU clock enable.
module test_mode_ctrl #(
   parameter  int SW_WIDTH   = 3,
   parameter  int NUM_MODES  = 5,
   parameter  int DIV_RATIO  = 4,
   parameter  int DEB_CYCLES = 3,
   parameter  int RST_HOLD   = 2,
   localparam int MCW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic [SW_WIDTH-1:0]  switch,
   input  logic                 run_en,
   input  logic                 step,
   output logic                 clk_en,
   output logic                 cpu_rst_n,
   output logic [NUM_MODES-1:0] mode,
   output logic [MCW-1:0]       mode_code,
   output logic                 mode_changed
);

   localparam int DW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   localparam logic [DW-1:0]     DIV_LAST  = DW'(DIV_RATIO - 1);
   localparam logic [HW-1:0]     HOLD_INIT = HW'(RST_HOLD);
   localparam logic [CW-1:0]     DEB_N     = CW'(DEB_CYCLES);
   localparam logic [SW_WIDTH:0] MODE_LIM  = (SW_WIDTH + 1)'(NUM_MODES);

   typedef enum logic {HOLD, RUN} state_t;

   logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
   logic [SW_WIDTH-1:0]  code_s, code_prev_q;
   logic [SW_WIDTH-1:0]  acc_q, acc_d;
   logic [CW-1:0]        deb_cnt_q, deb_cnt_d;
   logic                 step_meta_q, step_sync_q, step_prev_q;
   logic                 step_rise;
   logic                 accept, chg;
   logic [MCW-1:0]       mapped;
   state_t               state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [DW-1:0]        div_q, div_d;
   logic                 step_pls_q, step_pls_d;
   logic [MCW-1:0]       mode_code_q, mode_code_d;
   logic [NUM_MODES-1:0] mode_q, mode_d;
   logic                 chg_q;

   // switch[0] is the MSB of the mode code
   always_comb begin
      code_s = '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
         code_s[i] = sw_sync_q[SW_WIDTH-1-i];
      end
   end

   assign step_rise = step_sync_q & ~step_prev_q;

   always_comb begin
      deb_cnt_d = '0;
      acc_d     = acc_q;
      accept    = 1'b0;
      if (code_s != acc_q) begin
         deb_cnt_d = (code_s == code_prev_q) ? deb_cnt_q + 1'b1 : CW'(1);
         if (deb_cnt_d == DEB_N) begin
            accept    = 1'b1;
            acc_d     = code_s;
            deb_cnt_d = '0;
         end
      end
   end

   assign mapped = ({1'b0, acc_d} < MODE_LIM) ? MCW'(acc_d) : '0;
   assign chg    = accept && (mapped != mode_code_q);

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      div_d       = '0;
      step_pls_d  = 1'b0;
      mode_code_d = mode_code_q;
      mode_d      = mode_q;
      unique case (state_q)
         HOLD: begin
            if (hold_q == HW'(1)) state_d = RUN;
            else                  hold_d  = hold_q - 1'b1;
         end
         RUN: begin
            if (run_en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            else        step_pls_d = step_rise;
         end
         default: ;
      endcase
      // a mode change overrides everything, including a pending step
      if (chg) begin
         state_d     = HOLD;
         hold_d      = HOLD_INIT;
         div_d       = '0;
         step_pls_d  = 1'b0;
         mode_code_d = mapped;
         mode_d      = NUM_MODES'(1) << mapped;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
         code_prev_q <= '0;
         acc_q       <= '0;
         deb_cnt_q   <= '0;
         step_meta_q <= 1'b0;
         step_sync_q <= 1'b0;
         step_prev_q <= 1'b0;
         state_q     <= HOLD;
         hold_q      <= HOLD_INIT;
         div_q       <= '0;
         step_pls_q  <= 1'b0;
         mode_code_q <= '0;
         mode_q      <= NUM_MODES'(1);
         chg_q       <= 1'b0;
      end else begin
         sw_meta_q   <= switch;
         sw_sync_q   <= sw_meta_q;
         code_prev_q <= code_s;
         acc_q       <= acc_d;
         deb_cnt_q   <= deb_cnt_d;
         step_meta_q <= step;
         step_sync_q <= step_meta_q;
         step_prev_q <= step_sync_q;
         state_q     <= state_d;
         hold_q      <= hold_d;
         div_q       <= div_d;
         step_pls_q  <= step_pls_d;
         mode_code_q <= mode_code_d;
         mode_q      <= mode_d;
         chg_q       <= chg;
      end
   end

   assign cpu_rst_n    = (state_q == RUN);
   assign clk_en       = (state_q == RUN) &&
                         (run_en ? (div_q == DIV_LAST) : step_pls_q);
   assign mode         = mode_q;
   assign mode_code    = mode_code_q;
   assign mode_changed = chg_q;

endmodule

// File: tb/tb_test_mode_ctrl.sv
// Bench for test_mode_ctrl at default parameters: reset, cadence,
// debounce, mode mapping, single-step and reset recovery.
module tb_test_mode_ctrl;

   logic       clk = 1'b0;
   logic       RST;
   logic [2:0] switch;
   logic       run_en;
   logic       step;
   logic       clk_en;
   logic       cpu_rst_n;
   logic [4:0] mode;
   logic [2:0] mode_code;
   logic       mode_changed;

   int   checks = 0;
   int   errors = 0;
   logic en_q[$];
   int   code_q[$];

   test_mode_ctrl #(
      .SW_WIDTH(3), .NUM_MODES(5), .DIV_RATIO(4),
      .DEB_CYCLES(3), .RST_HOLD(2)
   ) dut (
      .clk(clk), .RST(RST), .switch(switch), .run_en(run_en),
      .step(step), .clk_en(clk_en), .cpu_rst_n(cpu_rst_n),
      .mode(mode), .mode_code(mode_code), .mode_changed(mode_changed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] sw_of(input int code);
      logic [2:0] c;
      c = 3'(code);
      return {c[0], c[1], c[2]};
   endfunction

   task automatic test_reset();
      RST = 1'b0; switch = 3'b000; run_en = 1'b1; step = 1'b0;
      repeat (3) tick();
      checks++;
      if (clk_en !== 1'b0) begin errors++;
         $display("FAIL rst_clk_en: got %b expected 0", clk_en); end
      checks++;
      if (cpu_rst_n !== 1'b0) begin errors++;
         $display("FAIL rst_cpu_rst_n: got %b expected 0", cpu_rst_n); end
      checks++;
      if (mode_code !== 3'd0) begin errors++;
         $display("FAIL rst_mode_code: got %0d expected 0", mode_code); end
      checks++;
      if (mode !== 5'b00001) begin errors++;
         $display("FAIL rst_mode: got %b expected 00001", mode); end
      checks++;
      if (mode_changed !== 1'b0) begin errors++;
         $display("FAIL rst_mode_changed: got %b expected 0", mode_changed); end
      RST = 1'b1;
      tick();
      checks++;
      if (cpu_rst_n !== 1'b0 || mode_changed !== 1'b0) begin errors++;
         $display("FAIL por_hold: got rst_n %b chg %b expected 0 0", cpu_rst_n, mode_changed); end
      tick();
      checks++;
      if (cpu_rst_n !== 1'b1) begin errors++;
         $display("FAIL por_run: got %b expected 1", cpu_rst_n); end
   endtask

   task automatic test_free_run();
      logic e;
      for (int c = 1; c <= 12; c++) en_q.push_back(c % 4 == 0);
      for (int c = 1; c <= 12; c++) begin
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e) begin errors++;
            $display("FAIL free_run_clk_en c%0d: got %b expected %b", c, clk_en, e); end
         tick();
      end
      checks++;
      if (mode !== 5'b00001 || cpu_rst_n !== 1'b1) begin errors++;
         $display("FAIL free_run_mode: got %b/%b expected 00001/1", mode, cpu_rst_n); end
   endtask

   task automatic test_glitch();
      logic e;
      for (int c = 13; c <= 28; c++) en_q.push_back(c % 4 == 0);
      for (int c = 13; c <= 28; c++) begin
         if (c == 13) switch = sw_of(4);
         if (c == 15) switch = sw_of(0);
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e || mode_changed !== 1'b0 || mode_code !== 3'd0) begin errors++;
            $display("FAIL glitch c%0d: got en %b chg %b code %0d expected %b 0 0",
                     c, clk_en, mode_changed, mode_code, e); end
         tick();
      end
   endtask

   task automatic test_mode_change(input int code);
      int         lat;
      int         exp_code;
      logic [4:0] exp_mode;
      logic       e;
      code_q.push_back((code >= 5) ? 0 : code);
      switch = sw_of(code);
      lat = 0;
      while (mode_changed !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 5) begin errors++;
         $display("FAIL chg_latency sw%0d: got %0d cycles expected 5", code, lat); end
      exp_code = code_q.pop_front();
      exp_mode = 5'b00001 << exp_code;
      checks++;
      if (mode_code !== 3'(exp_code) || mode !== exp_mode) begin errors++;
         $display("FAIL chg_mode sw%0d: got %0d/%b expected %0d/%b",
                  code, mode_code, mode, exp_code, exp_mode); end
      checks++;
      if (cpu_rst_n !== 1'b0 || clk_en !== 1'b0) begin errors++;
         $display("FAIL chg_hold1 sw%0d: got %b %b expected 0 0", code, cpu_rst_n, clk_en); end
      tick();
      checks++;
      if (cpu_rst_n !== 1'b0 || mode_changed !== 1'b0) begin errors++;
         $display("FAIL chg_hold2 sw%0d: got %b %b expected 0 0", code, cpu_rst_n, mode_changed); end
      tick();
      checks++;
      if (cpu_rst_n !== 1'b1) begin errors++;
         $display("FAIL chg_run sw%0d: got %b expected 1", code, cpu_rst_n); end
      for (int c = 1; c <= 4; c++) en_q.push_back(c == 4);
      for (int c = 1; c <= 4; c++) begin
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e) begin errors++;
            $display("FAIL chg_clk_en sw%0d c%0d: got %b expected %b", code, c, clk_en, e); end
         tick();
      end
   endtask

   task automatic test_code7_noop();
      switch = sw_of(7);
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (mode_changed !== 1'b0 || mode_code !== 3'd0 || cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL code7_noop c%0d: got chg %b code %0d rst_n %b expected 0 0 1",
                     c, mode_changed, mode_code, cpu_rst_n); end
         tick();
      end
   endtask

   task automatic test_step();
      logic e;
      int   pulses;
      run_en = 1'b0;
      pulses = 0;
      for (int k = 0; k < 30; k++) en_q.push_back(k == 7 || k == 15 || k == 23);
      for (int k = 0; k < 30; k++) begin
         if (k == 4 || k == 12 || k == 20) step = 1'b1;
         if (k == 7 || k == 15 || k == 23) step = 1'b0;
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e) begin errors++;
            $display("FAIL step_clk_en k%0d: got %b expected %b", k, clk_en, e); end
         if (clk_en === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 3) begin errors++;
         $display("FAIL step_count: got %0d expected 3", pulses); end
   endtask

   task automatic test_step_in_hold();
      int   pulses;
      logic e;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (k == 0) switch = sw_of(1);
         if (k == 3) step = 1'b1;
         if (k == 5) step = 1'b0;
         if (k == 5) begin
            checks++;
            if (mode_changed !== 1'b1 || mode_code !== 3'd1) begin errors++;
               $display("FAIL hold_step_chg: got %b %0d expected 1 1", mode_changed, mode_code); end
         end
         if (clk_en === 1'b1) pulses++;
         tick();
      end
      for (int k = 0; k < 20; k++) begin
         if (k == 0) switch = sw_of(2);
         if (k == 2) step = 1'b1;
         if (k == 4) step = 1'b0;
         if (k == 5) begin
            checks++;
            if (mode_changed !== 1'b1 || mode_code !== 3'd2) begin errors++;
               $display("FAIL tie_step_chg: got %b %0d expected 1 2", mode_changed, mode_code); end
         end
         if (clk_en === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin errors++;
         $display("FAIL hold_step_count: got %0d expected 0", pulses); end
      for (int k = 0; k < 8; k++) en_q.push_back(k == 3);
      for (int k = 0; k < 8; k++) begin
         if (k == 0) step = 1'b1;
         if (k == 3) step = 1'b0;
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e) begin errors++;
            $display("FAIL post_hold_step k%0d: got %b expected %b", k, clk_en, e); end
         tick();
      end
      run_en = 1'b1;
      for (int c = 1; c <= 4; c++) en_q.push_back(c == 4);
      for (int c = 1; c <= 4; c++) begin
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e) begin errors++;
            $display("FAIL run_restart c%0d: got %b expected %b", c, clk_en, e); end
         tick();
      end
   endtask

   task automatic test_reset_mid_run();
      logic e;
      repeat (3) tick();
      checks++;
      if (clk_en !== 1'b1 || mode_code !== 3'd4) begin errors++;
         $display("FAIL pre_reset: got en %b code %0d expected 1 4", clk_en, mode_code); end
      #3;
      RST = 1'b0;
      #1;
      checks++;
      if (mode_code !== 3'd0 || mode !== 5'b00001) begin errors++;
         $display("FAIL mid_rst_mode: got %0d/%b expected 0/00001", mode_code, mode); end
      checks++;
      if (cpu_rst_n !== 1'b0 || clk_en !== 1'b0 || mode_changed !== 1'b0) begin errors++;
         $display("FAIL mid_rst_out: got %b %b %b expected 0 0 0", cpu_rst_n, clk_en, mode_changed); end
      switch = 3'b000;
      tick();
      tick();
      RST = 1'b1;
      tick();
      checks++;
      if (cpu_rst_n !== 1'b0) begin errors++;
         $display("FAIL recov_hold: got %b expected 0", cpu_rst_n); end
      tick();
      checks++;
      if (cpu_rst_n !== 1'b1) begin errors++;
         $display("FAIL recov_run: got %b expected 1", cpu_rst_n); end
      for (int c = 1; c <= 8; c++) en_q.push_back(c % 4 == 0);
      for (int c = 1; c <= 8; c++) begin
         e = en_q.pop_front();
         checks++;
         if (clk_en !== e || mode_changed !== 1'b0 || mode !== 5'b00001) begin errors++;
            $display("FAIL recov c%0d: got en %b chg %b mode %b expected %b 0 00001",
                     c, clk_en, mode_changed, mode, e); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_glitch();
      test_mode_change(2);
      test_mode_change(0);
      test_code7_noop();
      test_mode_change(3);
      test_mode_change(7);
      test_step();
      test_step_in_hold();
      test_mode_change(4);
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/test_mode_ctrl.md
TEST_MODE_CTRL -- requirements
Module: test_mode_ctrl

Interface
REQ-001 The block SHALL have parameter SW_WIDTH, default 3, giving the number of mode-select switch bits.
REQ-002 The block SHALL have parameter NUM_MODES, default 5, giving the count of legal test-program modes; legal codes are 0..NUM_MODES-1.
REQ-003 The block SHALL have parameter DIV_RATIO, default 4, giving CPU clock-enable period in clk cycles (>=1).
REQ-004 The block SHALL have parameter DEB_CYCLES, default 3, giving consecutive stable synced cycles needed to accept a switch change (>=1).
REQ-005 The block SHALL have parameter RST_HOLD, default 2, giving clk cycles cpu_rst_n is held low per mode entry (>=1).
REQ-006 The block SHALL have these ports:
- clk  in  1  single clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- switch  in  SW_WIDTH  asynchronous mode-select switches
- run_en  in  1  1 = free-run, 0 = single-step (quasi-static)
- step  in  1  asynchronous single-step button
- clk_en  out  1  one-cycle CPU clock-enable pulse
- cpu_rst_n  out  1  active-low CPU/program reset
- mode  out  NUM_MODES  one-hot current mode
- mode_code  out  $clog2(NUM_MODES)  binary current mode
- mode_changed  out  1  one-cycle pulse on mode entry

Function
REQ-007 switch and step SHALL each pass through a 2-flop synchroniser before any use.
REQ-008 Switch code SHALL be bit-reversed: switch[0] is MSB, switch[SW_WIDTH-1] is LSB (3-bit: 001=1 total_circle, 010=2 condition, 011=3 condition_suc, 100=4 no_condition, 000=0 display).
REQ-009 Debounce: a synced code differing from the accepted code SHALL be accepted only after DEB_CYCLES consecutive identical synced cycles; any intervening change restarts the count; total latency from switch edge to acceptance is 2+DEB_CYCLES cycles.
REQ-010 Accepted codes >= NUM_MODES SHALL map to mode 0 (display).
REQ-011 FSM states SHALL be HOLD and RUN.
REQ-012 Accepting a code whose mapped mode differs from mode_code SHALL, in that cycle: update mode/mode_code, pulse mode_changed, clear divider, enter HOLD with counter = RST_HOLD.
REQ-013 Accepting a code mapping to the current mode SHALL cause no action.
REQ-014 In HOLD: cpu_rst_n = 0, clk_en = 0, step edges discarded; after RST_HOLD cycles go to RUN, cpu_rst_n = 1.
REQ-015 A mode change accepted while in HOLD SHALL restart the full RST_HOLD count with the new mode.
REQ-016 In RUN with run_en = 1: divider counts 0..DIV_RATIO-1, wraps to 0; clk_en = 1 exactly when counter = DIV_RATIO-1; DIV_RATIO = 1 gives clk_en every RUN cycle.
REQ-017 In RUN with run_en = 0: divider holds at 0; each synced rising edge of step gives exactly one clk_en pulse in the cycle after edge detection.
REQ-018 Mode change acceptance and step edge in the same cycle: mode change wins, step edge dropped.
REQ-019 run_en 0->1 SHALL restart divider from 0.

Reset
REQ-020 RST low SHALL asynchronously force: clk_en 0, cpu_rst_n 0, mode_code 0, mode = 1 (bit 0), mode_changed 0, synchronisers/debounce/divider 0, accepted code 0, FSM HOLD with counter = RST_HOLD.
REQ-021 After RST deasserts, HOLD SHALL run RST_HOLD cycles then enter RUN; no mode_changed pulse at power-on.
REQ-022 RST assertion mid-HOLD or mid-RUN SHALL abort everything and restart per REQ-020.

Verification (defaults)
REQ-023 Release RST, switch=000, run_en=1 -> cpu_rst_n low 2 cycles then high; clk_en on 4th RUN cycle and every 4 cycles thereafter; mode=00001.
REQ-024 switch 000->010 held -> mode_changed 5 cycles after edge, mode_code=2, cpu_rst_n low 2 cycles, clk_en 0 until 4th RUN cycle.
REQ-025 switch pulses 000->100 for 2 cycles then back -> no mode_changed, mode_code stays 0, clk_en cadence unbroken.
REQ-026 switch=111 (code 7) held -> accepted, maps to 0; from mode 0 no mode_changed; from mode 3 mode_changed and mode_code=0.
REQ-027 run_en=0, three clean step presses -> exactly three clk_en pulses; step press during HOLD -> none.
REQ-028 RST asserted mid-RUN in mode 4 -> immediate mode_code=0, cpu_rst_n=0, clk_en=0; recovery as REQ-023.
